// File: rtl/pong_pkg.sv
// Shared types and default rule constants for the ping-pong scorekeeper.
package pong_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } score_st_t;

    typedef enum logic {
        P1 = 1'b0,
        P2 = 1'b1
    } player_t;

    localparam int DEF_W        = 5;
    localparam int DEF_WIN_PTS  = 11;
    localparam int DEF_SRV_SWAP = 2;

    // Width of a counter that runs 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pong_score_keeper_if.sv
// Bundle between the game logic (master) and the scorekeeper (slave).
interface pong_score_keeper_if
    import pong_pkg::*;
#(
    parameter int W = DEF_W
);

    // Pulse protocol: new_game, pt_p1 and pt_p2 are one-cycle requests sampled on
    // every rising edge with no backpressure; score_upd and pt_err are one-cycle
    // acknowledgements appearing one edge after the request they answer.
    logic         new_game;
    logic         pt_p1;
    logic         pt_p2;
    logic [W-1:0] score_p1;
    logic [W-1:0] score_p2;
    logic         server;
    logic         playing;
    logic         game_over;
    logic         winner;
    logic         score_upd;
    logic         pt_err;
    score_st_t    state;

    modport master (
        output new_game, pt_p1, pt_p2,
        input  score_p1, score_p2, server, playing, game_over, winner,
        input  score_upd, pt_err, state
    );

    modport slave (
        input  new_game, pt_p1, pt_p2,
        output score_p1, score_p2, server, playing, game_over, winner,
        output score_upd, pt_err, state
    );

endinterface

// File: rtl/pong_score_keeper_inc_ha.sv
// Y = A + 1 as a ripple chain of half-adder cells; the carry out of the top
// stage is dropped because scores never reach the top of the range.
module ha_cell (
    input  logic a_i,
    input  logic b_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i;
    assign c_o = a_i & b_i;

endmodule

module inc_ha #(
    parameter int W = 5
) (
    input  logic [W-1:0] a_i,
    output logic [W-1:0] y_o
);

    logic [W:0] carry;
    logic       carry_unused;

    assign carry[0]     = 1'b1;
    assign carry_unused = carry[W];

    for (genvar i = 0; i < W; i++) begin : g_stage
        ha_cell u_ha (
            .a_i (a_i[i]),
            .b_i (carry[i]),
            .s_o (y_o[i]),
            .c_o (carry[i+1])
        );
    end

endmodule

// File: rtl/pong_score_keeper.sv
// Match scorekeeper: IDLE/PLAY/OVER FSM, per-player scores, service rotation,
// win-by-two detection with deuce normalisation, and registered event pulses.
module pong_score_keeper
    import pong_pkg::*;
#(
    parameter int W        = DEF_W,
    parameter int WIN_PTS  = DEF_WIN_PTS,
    parameter int SRV_SWAP = DEF_SRV_SWAP
) (
    input  logic                  clk,
    input  logic                  rst,
    pong_score_keeper_if.slave    bus
);

    localparam int            CW       = cnt_width(SRV_SWAP);
    localparam logic [W:0]    WIN_X    = (W+1)'(WIN_PTS);
    localparam logic [W:0]    MARGIN_X = (W+1)'(2);
    localparam logic [W-1:0]  WIN_S    = W'(WIN_PTS);
    localparam logic [W-1:0]  DEUCE_S  = W'(WIN_PTS - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SRV_SWAP - 1);

    score_st_t     state_q, state_d;
    logic [W-1:0]  score_p1_q, score_p1_d;
    logic [W-1:0]  score_p2_q, score_p2_d;
    logic [CW-1:0] srv_cnt_q, srv_cnt_d;
    logic          server_q, server_d;
    logic          winner_q, winner_d;
    logic          decided_q, decided_d;
    logic          score_upd_q, score_upd_d;
    logic          pt_err_q, pt_err_d;

    logic [W-1:0]  inc_p1, inc_p2;
    logic [W-1:0]  s_new, o_cur;
    player_t       scorer;
    logic          in_play, pt_one, pt_both, accept;
    logic          deuce, win_hit, tie_hit;

    inc_ha #(.W(W)) u_inc_p1 (
        .a_i (score_p1_q),
        .y_o (inc_p1)
    );

    inc_ha #(.W(W)) u_inc_p2 (
        .a_i (score_p2_q),
        .y_o (inc_p2)
    );

    // Rally decode and the compares on the scorer's incremented value.
    always_comb begin
        in_play = (state_q == PLAY);
        pt_one  = bus.pt_p1 ^ bus.pt_p2;
        pt_both = bus.pt_p1 & bus.pt_p2;
        accept  = in_play & pt_one & ~bus.new_game;
        scorer  = bus.pt_p2 ? P2 : P1;
        s_new   = (scorer == P1) ? inc_p1 : inc_p2;
        o_cur   = (scorer == P1) ? score_p2_q : score_p1_q;
        deuce   = (score_p1_q >= DEUCE_S) && (score_p2_q >= DEUCE_S);
        win_hit = ({1'b0, s_new} >= WIN_X) &&
                  ({1'b0, s_new} >= ({1'b0, o_cur} + MARGIN_X));
        tie_hit = (s_new == WIN_S) && (o_cur == WIN_S);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.new_game) begin
            state_d = PLAY;
        end else if (accept && win_hit) begin
            state_d = OVER;
        end
    end

    always_comb begin
        bus.state     = state_q;
        bus.playing   = (state_q == PLAY);
        bus.game_over = (state_q == OVER);
        bus.score_p1  = score_p1_q;
        bus.score_p2  = score_p2_q;
        bus.server    = server_q;
        bus.winner    = winner_q;
        bus.score_upd = score_upd_q;
        bus.pt_err    = pt_err_q;
    end

    always_comb begin
        score_p1_d  = score_p1_q;
        score_p2_d  = score_p2_q;
        srv_cnt_d   = srv_cnt_q;
        server_d    = server_q;
        winner_d    = winner_q;
        decided_d   = decided_q;
        score_upd_d = 1'b0;
        pt_err_d    = 1'b0;

        if (bus.new_game) begin
            score_p1_d = '0;
            score_p2_d = '0;
            srv_cnt_d  = '0;
            // The loser of the last finished game serves; none yet means player 1.
            server_d   = decided_q ? ~winner_q : 1'b0;
        end else if (in_play && pt_both) begin
            pt_err_d = 1'b1;
        end else if (accept) begin
            score_upd_d = 1'b1;
            if (tie_hit) begin
                score_p1_d = DEUCE_S;
                score_p2_d = DEUCE_S;
            end else if (scorer == P1) begin
                score_p1_d = s_new;
            end else begin
                score_p2_d = s_new;
            end

            if (win_hit) begin
                winner_d  = logic'(scorer);
                decided_d = 1'b1;
            end else if (deuce) begin
                server_d  = ~server_q;
                srv_cnt_d = '0;
            end else if (srv_cnt_q == CNT_LAST) begin
                server_d  = ~server_q;
                srv_cnt_d = '0;
            end else begin
                srv_cnt_d = srv_cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            score_p1_q  <= '0;
            score_p2_q  <= '0;
            srv_cnt_q   <= '0;
            server_q    <= 1'b0;
            winner_q    <= 1'b0;
            decided_q   <= 1'b0;
            score_upd_q <= 1'b0;
            pt_err_q    <= 1'b0;
        end else begin
            score_p1_q  <= score_p1_d;
            score_p2_q  <= score_p2_d;
            srv_cnt_q   <= srv_cnt_d;
            server_q    <= server_d;
            winner_q    <= winner_d;
            decided_q   <= decided_d;
            score_upd_q <= score_upd_d;
            pt_err_q    <= pt_err_d;
        end
    end

endmodule
